// File: rtl/idma_legalizer_burst_pkg.sv
// Shared types and helpers for the burst legalizer (word-based OBI/TXRX backends).
package idma_legalizer_burst_pkg;

  localparam int unsigned MaxOffW = 8;

  typedef logic [7:0]         beats_t;
  typedef logic [MaxOffW-1:0] offset_t;

  typedef struct packed {
    logic decouple;
    logic super_last;
  } opt_t;

  // Number of bus words touched by nbytes (counted from a word boundary), minus one.
  function automatic beats_t beats_from_bytes(input logic [63:0] nbytes, input int unsigned off_w);
    logic [63:0] words;
    if (nbytes == '0) return '0;
    words = (nbytes + ((64'd1 << off_w) - 64'd1)) >> off_w;
    return beats_t'(words - 64'd1);
  endfunction

endpackage

// File: rtl/idma_legalizer_burst_chunker.sv
// Combinational burst sizing: page-, burst- and cap-limited chunk for one machine.
module idma_legalizer_burst_chunker
  import idma_legalizer_burst_pkg::*;
#(
  parameter  int unsigned LenWidth  = 32,
  parameter  int unsigned StrbWidth = 4,
  parameter  int unsigned MaxBeats  = 4,
  parameter  int unsigned PageSize  = 64,
  localparam int unsigned PgW       = $clog2(PageSize),
  localparam int unsigned OffW      = $clog2(StrbWidth),
  localparam int unsigned LW1       = LenWidth + 1
) (
  input  logic [PgW-1:0]      page_off,
  input  logic [LenWidth-1:0] len,
  input  logic [LW1-1:0]      cap,
  output logic [LW1-1:0]      poss,
  output logic [LW1-1:0]      bytes,
  output beats_t              num_beats,
  output logic [OffW-1:0]     offset,
  output logic [OffW-1:0]     tailer
);

  logic [LW1-1:0] poss_page, poss_burst, end_b;

  always_comb begin
    offset     = page_off[OffW-1:0];
    poss_page  = LW1'(PageSize) - LW1'(page_off);
    poss_burst = LW1'(MaxBeats * StrbWidth) - LW1'(offset);
    poss       = (poss_page < poss_burst) ? poss_page : poss_burst;
    bytes      = LW1'(len);
    if (poss < bytes) bytes = poss;
    // cap carries the partner machine's limit in coupled mode, all-ones otherwise
    if (cap < bytes) bytes = cap;
    end_b      = LW1'(offset) + bytes;
    tailer     = end_b[OffW-1:0];
    num_beats  = beats_from_bytes(64'(end_b), OffW);
  end

endmodule

// File: rtl/idma_legalizer_burst_obi_txrx.sv
// Burst legalizer: splits 1D transfers into page-safe read/write bursts of up to MaxBeats words.
module idma_legalizer_burst_obi_txrx
  import idma_legalizer_burst_pkg::*;
#(
  parameter  int unsigned DataWidth       = 32,
  parameter  int unsigned AddrWidth       = 32,
  parameter  int unsigned LenWidth        = 32,
  parameter  int unsigned MaxBeats        = 4,
  parameter  int unsigned PageSize        = 64,
  parameter  bit          CombinedShifter = 1'b0,
  localparam int unsigned StrbWidth       = DataWidth / 8,
  localparam int unsigned OffW            = $clog2(StrbWidth)
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 req_valid_i,
  output logic                 req_ready_o,
  input  logic [AddrWidth-1:0] req_src_addr_i,
  input  logic [AddrWidth-1:0] req_dst_addr_i,
  input  logic [LenWidth-1:0]  req_length_i,
  input  logic                 req_decouple_i,
  input  logic                 req_last_i,
  output logic                 r_valid_o,
  input  logic                 r_ready_i,
  output logic [AddrWidth-1:0] r_addr_o,
  output logic [7:0]           r_num_beats_o,
  output logic [OffW-1:0]      r_offset_o,
  output logic [OffW-1:0]      r_tailer_o,
  output logic [OffW-1:0]      r_shift_o,
  output logic                 r_is_single_o,
  output logic                 w_valid_o,
  input  logic                 w_ready_i,
  output logic [AddrWidth-1:0] w_addr_o,
  output logic [7:0]           w_num_beats_o,
  output logic [OffW-1:0]      w_offset_o,
  output logic [OffW-1:0]      w_tailer_o,
  output logic [OffW-1:0]      w_shift_o,
  output logic                 w_is_single_o,
  output logic                 w_last_o,
  output logic                 w_super_last_o,
  input  logic                 flush_i,
  input  logic                 kill_i,
  output logic                 r_busy_o,
  output logic                 w_busy_o
);

  localparam int unsigned PgW = $clog2(PageSize);
  localparam int unsigned LW1 = LenWidth + 1;
  localparam int unsigned AW1 = AddrWidth + 1;

  logic [AddrWidth-1:0] r_addr_q, w_addr_q, r_addr_nxt, w_addr_nxt;
  logic [LenWidth-1:0]  r_len_q, w_len_q;
  logic                 r_active_q, w_active_q, r_wrap, w_wrap;
  opt_t                 opt_q;
  logic [OffW-1:0]      r_shift_q, w_shift_q, src_lo, dst_lo;

  logic [LW1-1:0] r_poss, w_poss, r_cap, w_cap, r_bytes, w_bytes;
  beats_t         r_beats, w_beats;
  logic           pair_valid, r_fire, w_fire, r_final, w_final, accept;

  assign r_cap = opt_q.decouple ? '1 : w_poss;
  assign w_cap = opt_q.decouple ? '1 : r_poss;

  idma_legalizer_burst_chunker #(
    .LenWidth(LenWidth), .StrbWidth(StrbWidth), .MaxBeats(MaxBeats), .PageSize(PageSize)
  ) u_r_chunk (
    .page_off(r_addr_q[PgW-1:0]), .len(r_len_q), .cap(r_cap), .poss(r_poss), .bytes(r_bytes),
    .num_beats(r_beats), .offset(r_offset_o), .tailer(r_tailer_o)
  );

  idma_legalizer_burst_chunker #(
    .LenWidth(LenWidth), .StrbWidth(StrbWidth), .MaxBeats(MaxBeats), .PageSize(PageSize)
  ) u_w_chunk (
    .page_off(w_addr_q[PgW-1:0]), .len(w_len_q), .cap(w_cap), .poss(w_poss), .bytes(w_bytes),
    .num_beats(w_beats), .offset(w_offset_o), .tailer(w_tailer_o)
  );

  // Coupled machines share one handshake: neither moves unless both sides are ready.
  assign pair_valid = r_active_q & w_active_q & ~flush_i;
  assign r_valid_o  = opt_q.decouple ? (r_active_q & ~flush_i) : pair_valid;
  assign w_valid_o  = opt_q.decouple ? (w_active_q & ~flush_i) : pair_valid;
  assign r_fire     = opt_q.decouple ? (r_valid_o & r_ready_i) : (pair_valid & r_ready_i & w_ready_i);
  assign w_fire     = opt_q.decouple ? (w_valid_o & w_ready_i) : (pair_valid & r_ready_i & w_ready_i);
  assign r_final    = r_fire & (LW1'(r_len_q) == r_bytes);
  assign w_final    = w_fire & (LW1'(w_len_q) == w_bytes);

  assign req_ready_o = (~r_active_q | r_final) & (~w_active_q | w_final) & ~flush_i & ~kill_i;
  assign accept      = req_valid_i & req_ready_o;

  assign {r_wrap, r_addr_nxt} = {1'b0, r_addr_q} + AW1'(r_bytes);
  assign {w_wrap, w_addr_nxt} = {1'b0, w_addr_q} + AW1'(w_bytes);

  assign src_lo = req_src_addr_i[OffW-1:0];
  assign dst_lo = req_dst_addr_i[OffW-1:0];

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_addr_q   <= '0;
      w_addr_q   <= '0;
      r_len_q    <= '0;
      w_len_q    <= '0;
      r_active_q <= 1'b0;
      w_active_q <= 1'b0;
      opt_q      <= '0;
      r_shift_q  <= '0;
      w_shift_q  <= '0;
    end else if (kill_i) begin
      r_active_q <= 1'b0;
      w_active_q <= 1'b0;
    end else if (accept) begin
      r_addr_q   <= req_src_addr_i;
      w_addr_q   <= req_dst_addr_i;
      r_len_q    <= req_length_i;
      w_len_q    <= req_length_i;
      r_active_q <= (req_length_i != '0);
      w_active_q <= (req_length_i != '0);
      opt_q      <= '{decouple: req_decouple_i, super_last: req_last_i};
      r_shift_q  <= CombinedShifter ? (src_lo - dst_lo) : src_lo;
      w_shift_q  <= CombinedShifter ? '0 : ('0 - dst_lo);
    end else begin
      if (r_fire) begin
        r_addr_q <= r_addr_nxt;
        r_len_q  <= r_len_q - LenWidth'(r_bytes);
        if (r_final) r_active_q <= 1'b0;
      end
      if (w_fire) begin
        w_addr_q <= w_addr_nxt;
        w_len_q  <= w_len_q - LenWidth'(w_bytes);
        if (w_final) w_active_q <= 1'b0;
      end
    end
  end

  assert property (@(posedge clk_i) disable iff (!rst_ni)
    !((r_fire & ~r_final & r_wrap) | (w_fire & ~w_final & w_wrap)));

  assign r_addr_o       = r_addr_q & ~AddrWidth'(StrbWidth - 1);
  assign w_addr_o       = w_addr_q & ~AddrWidth'(StrbWidth - 1);
  assign r_num_beats_o  = r_beats;
  assign w_num_beats_o  = w_beats;
  assign r_is_single_o  = r_active_q & (r_beats == '0);
  assign w_is_single_o  = w_active_q & (w_beats == '0);
  assign r_shift_o      = r_shift_q;
  assign w_shift_o      = w_shift_q;
  assign w_last_o       = w_active_q & (LW1'(w_len_q) == w_bytes);
  assign w_super_last_o = opt_q.super_last;
  assign r_busy_o       = r_active_q;
  assign w_busy_o       = w_active_q;

endmodule

// File: tb/tb_idma_legalizer_burst_obi_txrx.sv
// Directed bench for the burst legalizer (DataWidth=32, MaxBeats=4, PageSize=64).
module tb_idma_legalizer_burst_obi_txrx;

  logic        clk, rst_n;
  logic        req_valid, req_ready, req_decouple, req_last;
  logic [31:0] req_src, req_dst, req_len;
  logic        r_valid, r_ready, w_valid, w_ready;
  logic [31:0] r_addr, w_addr;
  logic [7:0]  r_beats, w_beats;
  logic [1:0]  r_off, r_tail, r_shift, w_off, w_tail, w_shift;
  logic        r_single, w_single, w_last, w_super_last;
  logic        flush, kill, r_busy, w_busy;

  int nchk = 0;
  int errs = 0;
  int waits;

  idma_legalizer_burst_obi_txrx dut (
    .clk_i(clk), .rst_ni(rst_n),
    .req_valid_i(req_valid), .req_ready_o(req_ready),
    .req_src_addr_i(req_src), .req_dst_addr_i(req_dst), .req_length_i(req_len),
    .req_decouple_i(req_decouple), .req_last_i(req_last),
    .r_valid_o(r_valid), .r_ready_i(r_ready), .r_addr_o(r_addr), .r_num_beats_o(r_beats),
    .r_offset_o(r_off), .r_tailer_o(r_tail), .r_shift_o(r_shift), .r_is_single_o(r_single),
    .w_valid_o(w_valid), .w_ready_i(w_ready), .w_addr_o(w_addr), .w_num_beats_o(w_beats),
    .w_offset_o(w_off), .w_tailer_o(w_tail), .w_shift_o(w_shift), .w_is_single_o(w_single),
    .w_last_o(w_last), .w_super_last_o(w_super_last),
    .flush_i(flush), .kill_i(kill), .r_busy_o(r_busy), .w_busy_o(w_busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    nchk++;
    if (obs !== exp) begin
      errs++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_r(input string tag, input logic [31:0] a, input int b, input int o, input int t);
    chk({tag, ".r_valid"}, 64'(r_valid), 64'd1);
    chk({tag, ".r_addr"},  64'(r_addr),  64'(a));
    chk({tag, ".r_beats"}, 64'(r_beats), 64'(b));
    chk({tag, ".r_off"},   64'(r_off),   64'(o));
    chk({tag, ".r_tail"},  64'(r_tail),  64'(t));
    chk({tag, ".r_single"}, 64'(r_single), 64'(b == 0));
  endtask

  task automatic chk_w(input string tag, input logic [31:0] a, input int b, input int o, input int t,
                       input bit l);
    chk({tag, ".w_valid"}, 64'(w_valid), 64'd1);
    chk({tag, ".w_addr"},  64'(w_addr),  64'(a));
    chk({tag, ".w_beats"}, 64'(w_beats), 64'(b));
    chk({tag, ".w_off"},   64'(w_off),   64'(o));
    chk({tag, ".w_tail"},  64'(w_tail),  64'(t));
    chk({tag, ".w_single"}, 64'(w_single), 64'(b == 0));
    chk({tag, ".w_last"},  64'(w_last),  64'(l));
  endtask

  // Present a request and hold it until accepted; returns at edge+1 after acceptance.
  task automatic send(input logic [31:0] s, input logic [31:0] d, input logic [31:0] l,
                      input bit dec, input bit lst, output int nw);
    req_src = s; req_dst = d; req_len = l; req_decouple = dec; req_last = lst;
    req_valid = 1'b1;
    nw = 0;
    while (!req_ready && nw < 50) begin
      @(posedge clk); #1;
      nw++;
    end
    if (!req_ready) chk("send_timeout", 64'd0, 64'd1);
    @(posedge clk); #1;
    req_valid = 1'b0;
  endtask

  task automatic drain(input string tag);
    int n;
    r_ready = 1'b1; w_ready = 1'b1;
    n = 0;
    while ((r_busy || w_busy) && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    chk({tag, ".drained"}, 64'(r_busy | w_busy), 64'd0);
    r_ready = 1'b0; w_ready = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    rst_n = 1'b0; req_valid = 1'b0; req_src = '0; req_dst = '0; req_len = '0;
    req_decouple = 1'b0; req_last = 1'b0; r_ready = 1'b0; w_ready = 1'b0;
    flush = 1'b0; kill = 1'b0;
    #3;
    chk("rst.req_ready", 64'(req_ready), 64'd1);
    chk("rst.r_valid", 64'(r_valid), 64'd0);
    chk("rst.w_valid", 64'(w_valid), 64'd0);
    chk("rst.busy", 64'({r_busy, w_busy}), 64'd0);
    chk("rst.r_addr", 64'(r_addr), 64'd0);
    chk("rst.beats", 64'({r_beats, w_beats}), 64'd0);
    chk("rst.single", 64'({r_single, w_single}), 64'd0);
    chk("rst.last", 64'({w_last, w_super_last}), 64'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;

    // Decoupled split: src 0x02 / dst 0x10, 20 bytes
    send(32'h02, 32'h10, 32'd20, 1'b1, 1'b0, waits);
    chk_r("dec.r0", 32'h00, 3, 2, 0);
    chk("dec.r_shift", 64'(r_shift), 64'd2);
    chk("dec.w_shift", 64'(w_shift), 64'd0);
    chk_w("dec.w0", 32'h10, 3, 0, 0, 1'b0);
    r_ready = 1'b1;
    @(posedge clk); #1;
    chk_r("dec.r1", 32'h10, 1, 0, 2);
    chk("dec.w0_hold", 64'(w_addr), 64'h10);
    @(posedge clk); #1;
    chk("dec.r_done_valid", 64'(r_valid), 64'd0);
    chk("dec.r_done_busy", 64'(r_busy), 64'd0);
    r_ready = 1'b0; w_ready = 1'b1;
    @(posedge clk); #1;
    chk_w("dec.w1", 32'h20, 0, 0, 0, 1'b1);
    @(posedge clk); #1;
    chk("dec.w_done", 64'({w_valid, w_busy}), 64'd0);
    w_ready = 1'b0;

    // Page crossing: no burst spans 0x40
    send(32'h3C, 32'h80, 32'd8, 1'b1, 1'b0, waits);
    chk_r("pg.r0", 32'h3C, 0, 0, 0);
    chk_w("pg.w0", 32'h80, 1, 0, 0, 1'b1);
    r_ready = 1'b1;
    @(posedge clk); #1;
    chk_r("pg.r1", 32'h40, 0, 0, 0);
    drain("pg");

    // Coupled: common chunk sizes 14 then 6
    send(32'h02, 32'h10, 32'd20, 1'b0, 1'b0, waits);
    chk_r("cpl.r0", 32'h00, 3, 2, 0);
    chk_w("cpl.w0", 32'h10, 3, 0, 2, 1'b0);
    r_ready = 1'b1;
    @(posedge clk); #1;
    chk("cpl.r_wait_addr", 64'(r_addr), 64'h00);
    chk("cpl.pair_valid", 64'({r_valid, w_valid}), 64'h3);
    w_ready = 1'b1;
    @(posedge clk); #1;
    chk_r("cpl.r1", 32'h10, 1, 0, 2);
    chk_w("cpl.w1", 32'h1C, 1, 2, 0, 1'b1);
    @(posedge clk); #1;
    chk("cpl.done", 64'({r_valid, w_valid, r_busy, w_busy}), 64'd0);
    r_ready = 1'b0; w_ready = 1'b0;

    // Backpressure then flush
    send(32'h04, 32'h08, 32'd16, 1'b1, 1'b0, waits);
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      chk($sformatf("bp.hold%0d.addr", i), 64'(r_addr), 64'h04);
      chk($sformatf("bp.hold%0d.beats", i), 64'(r_beats), 64'd3);
    end
    flush = 1'b1; #1;
    chk("fl.valids", 64'({r_valid, w_valid}), 64'd0);
    chk("fl.req_ready", 64'(req_ready), 64'd0);
    r_ready = 1'b1; w_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("fl.frozen_busy", 64'({r_busy, w_busy}), 64'h3);
    flush = 1'b0; #1;
    chk_r("fl.resume_r", 32'h04, 3, 0, 0);
    chk_w("fl.resume_w", 32'h08, 3, 0, 0, 1'b1);
    drain("fl");

    // Zero length: accepted, nothing emitted
    send(32'h10, 32'h20, 32'd0, 1'b1, 1'b0, waits);
    chk("zero.busy", 64'({r_busy, w_busy}), 64'd0);
    chk("zero.valids", 64'({r_valid, w_valid}), 64'd0);
    chk("zero.req_ready", 64'(req_ready), 64'd1);

    // Kill after the first burst of a 64-byte transfer
    r_ready = 1'b1; w_ready = 1'b1;
    send(32'h00, 32'h100, 32'd64, 1'b1, 1'b0, waits);
    chk_r("kill.r0", 32'h00, 3, 0, 0);
    @(posedge clk); #1;
    chk("kill.r1_addr", 64'(r_addr), 64'h10);
    kill = 1'b1; #1;
    chk("kill.req_ready", 64'(req_ready), 64'd0);
    @(posedge clk); #1;
    kill = 1'b0; #1;
    chk("kill.busy", 64'({r_busy, w_busy}), 64'd0);
    chk("kill.valids", 64'({r_valid, w_valid}), 64'd0);
    chk("kill.req_ready_after", 64'(req_ready), 64'd1);
    send(32'h200, 32'h300, 32'd4, 1'b1, 1'b0, waits);
    chk("kill.next_waits", 64'(waits), 64'd0);
    chk_r("kill.next_r", 32'h200, 0, 0, 0);
    drain("kill");

    // Back-to-back aligned len-4 requests
    r_ready = 1'b1; w_ready = 1'b1;
    send(32'h40, 32'h80, 32'd4, 1'b1, 1'b0, waits);
    req_src = 32'h44; req_dst = 32'h84; req_len = 32'd4; req_last = 1'b1; req_valid = 1'b1;
    #1;
    chk("b2b.ready_on_final", 64'(req_ready), 64'd1);
    chk_r("b2b.r0", 32'h40, 0, 0, 0);
    chk_w("b2b.w0", 32'h80, 0, 0, 0, 1'b1);
    chk("b2b.super0", 64'(w_super_last), 64'd0);
    @(posedge clk); #1;
    req_valid = 1'b0;
    chk_r("b2b.r1", 32'h44, 0, 0, 0);
    chk_w("b2b.w1", 32'h84, 0, 0, 0, 1'b1);
    chk("b2b.super1", 64'(w_super_last), 64'd1);
    @(posedge clk); #1;
    chk("b2b.done", 64'({r_valid, w_valid, r_busy, w_busy}), 64'd0);
    r_ready = 1'b0; w_ready = 1'b0;

    $display("Result: errors=%0d of %0d checks", errs, nchk);
    $finish;
  end

endmodule
